// File: rtl/board_io_pkg.sv
// Shared board I/O types and timing constants for the button conditioning path.
package board_io_pkg;

    localparam int unsigned CLK_HZ        = 100_000_000;
    localparam int unsigned DEBOUNCE_10MS = 1_000_000;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FIRST,
        REPEAT
    } step_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus stable-count debouncer for one raw push-button.
module btn_debounce
    import board_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic level_o,
    output logic level_next_o
);

    localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          level_q;
    logic          level_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // The next level lets the step logic register its pulse on the same edge the level rises.
    assign level_o      = level_q;
    assign level_next_o = level_d;

endmodule

// File: rtl/button_step_conditioner.sv
// Turns the debounced left/right buttons into single-cycle step pulses with auto-repeat.
module button_step_conditioner
    import board_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS,
    parameter int unsigned REPEAT_DELAY    = 50_000_000,
    parameter int unsigned REPEAT_PERIOD   = 15_000_000
) (
    input  logic clk_100mhz,
    input  logic rst,
    input  logic btn_left,
    input  logic btn_right,
    output logic step_left,
    output logic step_right,
    output logic level_left,
    output logic level_right
);

    localparam int unsigned   RMAX        = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned   RW          = $clog2(RMAX + 1);
    localparam logic [RW-1:0] DELAY_LAST  = (REPEAT_DELAY == 0) ? '0 : RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    logic [1:0]    lvl_q;
    logic [1:0]    lvl_n;
    logic          hold;
    step_state_e   state_q [2];
    step_state_e   state_d [2];
    logic [RW-1:0] rcnt_q  [2];
    logic [RW-1:0] rcnt_d  [2];
    logic [1:0]    step_q;
    logic [1:0]    step_d;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_left (
        .clk_i       (clk_100mhz),
        .rst_i       (rst),
        .btn_i       (btn_left),
        .level_o     (lvl_q[0]),
        .level_next_o(lvl_n[0])
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_right (
        .clk_i       (clk_100mhz),
        .rst_i       (rst),
        .btn_i       (btn_right),
        .level_o     (lvl_q[1]),
        .level_next_o(lvl_n[1])
    );

    // Holding through the edge where one level falls restarts the survivor's delay from that edge.
    assign hold = (&lvl_n) | (&lvl_q);

    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 2; i++) begin
                state_q[i] <= IDLE;
                rcnt_q[i]  <= '0;
            end
            step_q <= '0;
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
                rcnt_q[i]  <= rcnt_d[i];
            end
            step_q <= step_d;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            rcnt_d[i]  = '0;
            step_d[i]  = 1'b0;
            if (!lvl_n[i]) begin
                state_d[i] = IDLE;
            end else if (hold) begin
                state_d[i] = WAIT_FIRST;
            end else begin
                case (state_q[i])
                    IDLE: begin
                        state_d[i] = WAIT_FIRST;
                        step_d[i]  = 1'b1;
                    end
                    WAIT_FIRST: begin
                        if (REPEAT_DELAY != 0) begin
                            if (rcnt_q[i] == DELAY_LAST) begin
                                state_d[i] = REPEAT;
                                step_d[i]  = 1'b1;
                            end else begin
                                rcnt_d[i] = rcnt_q[i] + 1'b1;
                            end
                        end
                    end
                    REPEAT: begin
                        if (rcnt_q[i] == PERIOD_LAST) begin
                            step_d[i] = 1'b1;
                        end else begin
                            rcnt_d[i] = rcnt_q[i] + 1'b1;
                        end
                    end
                    default: state_d[i] = IDLE;
                endcase
            end
        end
    end

    assign step_left   = step_q[0];
    assign step_right  = step_q[1];
    assign level_left  = lvl_q[0];
    assign level_right = lvl_q[1];

endmodule

// File: tb/tb_button_step_conditioner.sv
// Directed and random checks of button_step_conditioner against a schedule-based reference model.
module tb_button_step_conditioner;

    localparam int unsigned D     = 4;
    localparam int unsigned RP    = 3;
    localparam logic [7:0]  WMASK = 8'((1 << D) - 1);

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0][1:0] btn;
    logic [1:0][1:0] stp;
    logic [1:0][1:0] lv;

    int unsigned rdel [2] = '{10, 0};
    logic [7:0]  hist   [2][2];
    bit          mlvl   [2][2];
    bit          mstep  [2][2];
    int          anchor [2][2];
    int          pc     [2][2];
    int          t;
    int          n_checks;
    int          n_fail;
    int          ev;
    int          p;
    int          k;
    int          exp_cnt;

    always #5 clk = ~clk;

    button_step_conditioner #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(10), .REPEAT_PERIOD(RP)) dut (
        .clk_100mhz (clk),
        .rst        (rst),
        .btn_left   (btn[0][0]),
        .btn_right  (btn[0][1]),
        .step_left  (stp[0][0]),
        .step_right (stp[0][1]),
        .level_left (lv[0][0]),
        .level_right(lv[0][1])
    );

    button_step_conditioner #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(0), .REPEAT_PERIOD(RP)) dut_norep (
        .clk_100mhz (clk),
        .rst        (rst),
        .btn_left   (btn[1][0]),
        .btn_right  (btn[1][1]),
        .step_left  (stp[1][0]),
        .step_right (stp[1][1]),
        .level_left (lv[1][0]),
        .level_right(lv[1][1])
    );

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int b = 0; b < 2; b++) begin
                hist[d][b]   = '0;
                mlvl[d][b]   = 1'b0;
                mstep[d][b]  = 1'b0;
                anchor[d][b] = 0;
            end
        end
    endfunction

    // Level flips once the last D synchronized samples all disagree with it; pulses follow
    // the press/repeat schedule measured from an anchor cycle.
    function automatic void model_step();
        bit         nl [2][2];
        bit         hold;
        logic [7:0] win;
        int         e;
        t++;
        if (rst) begin
            model_reset();
            return;
        end
        for (int d = 0; d < 2; d++) begin
            for (int b = 0; b < 2; b++) begin
                hist[d][b] = {hist[d][b][6:0], btn[d][b]};
                win        = (hist[d][b] >> 2) & WMASK;
                if (mlvl[d][b] ? (win == 8'h00) : (win == WMASK)) nl[d][b] = ~mlvl[d][b];
                else nl[d][b] = mlvl[d][b];
            end
        end
        for (int d = 0; d < 2; d++) begin
            hold = (nl[d][0] && nl[d][1]) || (mlvl[d][0] && mlvl[d][1]);
            for (int b = 0; b < 2; b++) begin
                mstep[d][b] = 1'b0;
                if (!nl[d][b]) begin
                    mstep[d][b] = 1'b0;
                end else if (hold) begin
                    anchor[d][b] = t;
                end else if (!mlvl[d][b]) begin
                    anchor[d][b] = t;
                    mstep[d][b]  = 1'b1;
                end else begin
                    e = t - anchor[d][b];
                    mstep[d][b] = (rdel[d] != 0) && (e >= int'(rdel[d])) && (((e - int'(rdel[d])) % RP) == 0);
                end
            end
            for (int b = 0; b < 2; b++) mlvl[d][b] = nl[d][b];
        end
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("dut%0d_cycle", d),
                {4'h0, stp[d][0], stp[d][1], lv[d][0], lv[d][1]},
                {4'h0, mstep[d][0], mstep[d][1], mlvl[d][0], mlvl[d][1]});
            for (int b = 0; b < 2; b++) pc[d][b] += int'(stp[d][b]);
        end
    endtask

    task automatic clear_pc();
        for (int d = 0; d < 2; d++)
            for (int b = 0; b < 2; b++) pc[d][b] = 0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        t        = 0;
        btn      = '0;
        rst      = 1'b1;
        model_reset();
        clear_pc();
        #1;
        chk("reset_state", 8'({stp, lv}), 8'h00);
        tick();
        tick();
        rst = 1'b0;
        repeat (3) tick();

        // Clean press
        clear_pc();
        btn[0][0] = 1'b1;
        tick();
        ev = t;
        repeat (4) tick();
        chk("clean_before_level", {6'h0, lv[0][0], stp[0][0]}, 8'h00);
        tick();
        chk("clean_press_edge5", {6'h0, lv[0][0], stp[0][0]}, 8'h03);
        tick();
        chk("clean_single_cycle", {7'h0, stp[0][0]}, 8'h00);
        tick();
        btn[0][0] = 1'b0;
        repeat (12) tick();
        chk("clean_no_right", 8'(pc[0][1]), 8'h00);
        chk("clean_one_left", 8'(pc[0][0]), 8'h01);

        // Bounce rejection
        clear_pc();
        for (int i = 0; i < 20;) begin
            int run;
            run = int'($urandom_range(1, 3));
            btn[0][1] = ~btn[0][1];
            repeat (run) tick();
            i += run;
        end
        btn[0][1] = 1'b0;
        repeat (2) tick();
        chk("bounce_no_pulse", 8'(pc[0][1]), 8'h00);
        btn[0][1] = 1'b1;
        tick();
        ev = t;
        repeat (5) tick();
        chk("bounce_final_pulse", {7'h0, stp[0][1]}, 8'h01);
        repeat (2) tick();
        btn[0][1] = 1'b0;
        repeat (12) tick();
        chk("bounce_one_pulse", 8'(pc[0][1]), 8'h01);

        // Auto-repeat
        clear_pc();
        btn[0][0] = 1'b1;
        tick();
        p = t + 5;
        while (t < p + 29) begin
            tick();
            if (t == p || t == p + 10 || t == p + 13 || t == p + 16)
                chk("repeat_pulse", {7'h0, stp[0][0]}, 8'h01);
        end
        btn[0][0] = 1'b0;
        while (t < p + 45) tick();
        exp_cnt = 1;
        for (int j = p + 10; j < p + 35; j += int'(RP)) exp_cnt++;
        chk("repeat_pulse_count", 8'(pc[0][0]), 8'(exp_cnt));

        // Simultaneous press, then right release
        clear_pc();
        btn[0] = 2'b11;
        tick();
        ev = t;
        while (t < ev + 19) begin
            tick();
            if (t == ev + 5) chk("simul_levels", {6'h0, lv[0][0], lv[0][1]}, 8'h03);
        end
        chk("simul_no_pulse", 8'(pc[0][0] + pc[0][1]), 8'h00);
        btn[0][1] = 1'b0;
        while (t < ev + 34) begin
            tick();
            if (t == ev + 25) chk("simul_right_fall", {7'h0, lv[0][1]}, 8'h00);
        end
        chk("simul_no_early_left", 8'(pc[0][0]), 8'h00);
        tick();
        chk("simul_resume_pulse", {7'h0, stp[0][0]}, 8'h01);
        btn[0][0] = 1'b0;
        repeat (15) tick();

        // Reset mid-press
        btn[0][0] = 1'b1;
        tick();
        ev = t;
        while (t < ev + 7) tick();
        rst = 1'b1;
        model_reset();
        #1;
        chk("reset_async_outputs", 8'({stp, lv}), 8'h00);
        tick();
        tick();
        rst = 1'b0;
        clear_pc();
        tick();
        k = t;
        while (t < k + 5) tick();
        chk("reset_fresh_pulse", {7'h0, stp[0][0]}, 8'h01);
        while (t < k + 9) tick();
        chk("reset_one_pulse", 8'(pc[0][0]), 8'h01);
        btn[0][0] = 1'b0;
        repeat (15) tick();

        // Repeat disabled
        clear_pc();
        btn[1][1] = 1'b1;
        repeat (50) tick();
        btn[1][1] = 1'b0;
        repeat (15) tick();
        chk("norepeat_one_pulse", 8'(pc[1][1]), 8'h01);

        // Random buttons on both instances
        for (int i = 0; i < 600; i++) begin
            for (int d = 0; d < 2; d++)
                for (int b = 0; b < 2; b++)
                    if ($urandom_range(0, 7) == 0) btn[d][b] = ~btn[d][b];
            tick();
        end
        btn = '0;
        repeat (20) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog t=%0d observed=timeout expected=finish", t);
        $fatal(1, "watchdog expired");
    end

endmodule
